// File: rtl/spio_link_pkg.sv
// Shared definitions for the SpiNNaker-link receive path: 2-of-7 symbol
// transition codes, frame lengths in nibbles and the decoder state type.
package spio_link_pkg;

  // Transition patterns (old wires XOR new wires) for each data nibble.
  localparam logic [6:0] SYM_0   = 7'h11;
  localparam logic [6:0] SYM_1   = 7'h12;
  localparam logic [6:0] SYM_2   = 7'h14;
  localparam logic [6:0] SYM_3   = 7'h18;
  localparam logic [6:0] SYM_4   = 7'h21;
  localparam logic [6:0] SYM_5   = 7'h22;
  localparam logic [6:0] SYM_6   = 7'h24;
  localparam logic [6:0] SYM_7   = 7'h28;
  localparam logic [6:0] SYM_8   = 7'h41;
  localparam logic [6:0] SYM_9   = 7'h42;
  localparam logic [6:0] SYM_A   = 7'h44;
  localparam logic [6:0] SYM_B   = 7'h48;
  localparam logic [6:0] SYM_C   = 7'h03;
  localparam logic [6:0] SYM_D   = 7'h06;
  localparam logic [6:0] SYM_E   = 7'h0C;
  localparam logic [6:0] SYM_F   = 7'h09;
  localparam logic [6:0] SYM_EOP = 7'h60;

  // Frame lengths: header bit 1 selects between them.
  localparam logic [4:0] SHORT_NIBBLES = 5'd10;
  localparam logic [4:0] LONG_NIBBLES  = 5'd18;
  localparam int         SHORT_BITS    = 40;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RECV    = 2'd1,
    ST_STALL   = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

endpackage

// File: rtl/spio_link_2of7_decode.sv
// Combinational 2-of-7 transition decoder. A two-wire transition in the
// code table is a symbol; any other transition of two or more wires is an
// error; fewer than two wires means the symbol is still arriving.
module spio_link_2of7_decode
  import spio_link_pkg::*;
(
  input  logic [6:0] t,
  output logic       valid,
  output logic       eop,
  output logic [3:0] nibble,
  output logic       err
);

  // Table lookup plus error classification of the current transition.
  always_comb begin
    valid  = 1'b1;
    eop    = 1'b0;
    nibble = 4'h0;
    case (t)
      SYM_0:   nibble = 4'h0;
      SYM_1:   nibble = 4'h1;
      SYM_2:   nibble = 4'h2;
      SYM_3:   nibble = 4'h3;
      SYM_4:   nibble = 4'h4;
      SYM_5:   nibble = 4'h5;
      SYM_6:   nibble = 4'h6;
      SYM_7:   nibble = 4'h7;
      SYM_8:   nibble = 4'h8;
      SYM_9:   nibble = 4'h9;
      SYM_A:   nibble = 4'hA;
      SYM_B:   nibble = 4'hB;
      SYM_C:   nibble = 4'hC;
      SYM_D:   nibble = 4'hD;
      SYM_E:   nibble = 4'hE;
      SYM_F:   nibble = 4'hF;
      SYM_EOP: eop    = 1'b1;
      default: valid  = 1'b0;
    endcase
    err = !valid && ($countones(t) >= 2);
  end

endmodule

// File: rtl/spio_spinnaker_link_rx_decoder.sv
// SpiNNaker-link receiver: turns synchronized 2-of-7 NRZ wires into
// 40/72-bit packets on a valid/ready port, returning a transition ack per
// consumed symbol. Output backpressure is applied by withholding the ack
// of a good end-of-packet symbol.
module spio_spinnaker_link_rx_decoder
  import spio_link_pkg::*;
#(
  parameter int PKT_BITS = 72
)
(
  input  logic                CLK_IN,
  input  logic                RESET_IN,
  input  logic [6:0]          DATA_IN,
  output logic                ACK_OUT,
  output logic [PKT_BITS-1:0] PKT_DATA_OUT,
  output logic                PKT_LONG_OUT,
  output logic                PKT_VLD_OUT,
  input  logic                PKT_RDY_IN,
  output logic                FRM_ERR_OUT,
  output logic                PAR_ERR_OUT
);

  localparam logic [PKT_BITS-1:0] SHORT_MASK =
    {{(PKT_BITS-SHORT_BITS){1'b0}}, {SHORT_BITS{1'b1}}};

  state_e              state_q, state_d;
  logic [6:0]          old_q, old_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [PKT_BITS-1:0] asm_q, asm_d;
  logic                ack_q, ack_d;
  logic [PKT_BITS-1:0] data_q, data_d;
  logic                long_q, long_d;
  logic                vld_q, vld_d;
  logic                frm_q, frm_d;
  logic                par_q, par_d;

  // A complete frame carries odd parity over all of its bits.
  function automatic logic odd_parity(input logic [PKT_BITS-1:0] v);
    return ^v;
  endfunction

  logic [6:0] trans;
  logic       dec_valid, dec_eop, dec_err;
  logic [3:0] dec_nib;

  assign trans = DATA_IN ^ old_q;

  spio_link_2of7_decode u_decode (
    .t      (trans),
    .valid  (dec_valid),
    .eop    (dec_eop),
    .nibble (dec_nib),
    .err    (dec_err)
  );

  logic                in_recv, in_disc, in_stall, listening;
  logic                nib_ev, overflow, eop_ev, len_ok, eop_good;
  logic                sym_err, stall_go, stall_take, deliver, load, par_fail;
  logic                consume, clr_cnt, disc_eop;
  logic [4:0]          exp_len;
  logic [PKT_BITS-1:0] frame;

  assign in_recv    = (state_q == ST_RECV);
  assign in_disc    = (state_q == ST_DISCARD);
  assign in_stall   = (state_q == ST_STALL);
  assign listening  = in_recv || in_disc;

  assign exp_len    = asm_q[1] ? LONG_NIBBLES : SHORT_NIBBLES;
  assign len_ok     = (cnt_q == exp_len);
  assign nib_ev     = in_recv && dec_valid && !dec_eop;
  assign overflow   = nib_ev && (cnt_q == LONG_NIBBLES);
  assign eop_ev     = in_recv && dec_valid && dec_eop;
  assign eop_good   = eop_ev && len_ok;
  assign disc_eop   = in_disc && dec_valid && dec_eop;
  assign sym_err    = listening && dec_err;

  // A good EOP is held back while the output slot is occupied and not
  // being drained; it is taken later from STALL once the consumer is ready.
  assign stall_go   = eop_good && vld_q && !PKT_RDY_IN;
  assign stall_take = in_stall && PKT_RDY_IN;
  assign deliver    = (eop_good && !stall_go) || stall_take;

  assign frame      = asm_q[1] ? asm_q : (asm_q & SHORT_MASK);
  assign load       = deliver && odd_parity(frame);
  assign par_fail   = deliver && !odd_parity(frame);

  assign consume    = (listening && (dec_valid || dec_err) && !stall_go) || stall_take;
  assign clr_cnt    = sym_err || overflow || (eop_ev && !stall_go) || disc_eop || stall_take;

  // State register and all datapath/output registers.
  always_ff @(posedge CLK_IN or negedge RESET_IN) begin
    if (!RESET_IN) begin
      state_q <= ST_INIT;
      old_q   <= '0;
      cnt_q   <= '0;
      asm_q   <= '0;
      ack_q   <= 1'b0;
      data_q  <= '0;
      long_q  <= 1'b0;
      vld_q   <= 1'b0;
      frm_q   <= 1'b0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      old_q   <= old_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
      long_q  <= long_d;
      vld_q   <= vld_d;
      frm_q   <= frm_d;
      par_q   <= par_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: state_d = ST_RECV;
      ST_RECV: begin
        if (sym_err || overflow) state_d = ST_DISCARD;
        else if (stall_go)       state_d = ST_STALL;
      end
      ST_STALL: begin
        if (PKT_RDY_IN) state_d = ST_RECV;
      end
      ST_DISCARD: begin
        if (disc_eop) state_d = ST_RECV;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Symbol consumption, packet assembly and output register updates.
  always_comb begin
    old_d  = old_q;
    cnt_d  = cnt_q;
    asm_d  = asm_q;
    ack_d  = ack_q ^ consume;
    data_d = data_q;
    long_d = long_q;
    vld_d  = (vld_q && !PKT_RDY_IN) || load;
    frm_d  = sym_err || overflow || (eop_ev && !len_ok);
    par_d  = par_fail;

    if ((state_q == ST_INIT) || consume) old_d = DATA_IN;

    if (clr_cnt) begin
      cnt_d = '0;
    end else if (nib_ev) begin
      cnt_d = cnt_q + 5'd1;
      for (int n = 0; n < int'(LONG_NIBBLES); n++) begin
        if (cnt_q == n[4:0]) asm_d[4*n +: 4] = dec_nib;
      end
    end

    if (load) begin
      data_d = frame;
      long_d = asm_q[1];
    end
  end

  // Output assignment.
  always_comb begin
    ACK_OUT      = ack_q;
    PKT_DATA_OUT = data_q;
    PKT_LONG_OUT = long_q;
    PKT_VLD_OUT  = vld_q;
    FRM_ERR_OUT  = frm_q;
    PAR_ERR_OUT  = par_q;
  end

endmodule

// File: tb/tb_spio_spinnaker_link_rx_decoder.sv
// Directed bench for the SpiNNaker-link receive decoder: acts as the link
// transmitter on DATA_IN and as the packet consumer on the ready port.
module tb_spio_spinnaker_link_rx_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  data_in;
  logic        ack;
  logic [71:0] pkt_data;
  logic        pkt_long;
  logic        pkt_vld;
  logic        pkt_rdy;
  logic        frm_err;
  logic        par_err;

  always #5 clk = ~clk;

  spio_spinnaker_link_rx_decoder #(.PKT_BITS(72)) dut (
    .CLK_IN       (clk),
    .RESET_IN     (rst_n),
    .DATA_IN      (data_in),
    .ACK_OUT      (ack),
    .PKT_DATA_OUT (pkt_data),
    .PKT_LONG_OUT (pkt_long),
    .PKT_VLD_OUT  (pkt_vld),
    .PKT_RDY_IN   (pkt_rdy),
    .FRM_ERR_OUT  (frm_err),
    .PAR_ERR_OUT  (par_err)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [6:0]  wires = 7'h00;

  int          ack_cnt = 0, frm_cnt = 0, par_cnt = 0, xfer_cnt = 0;
  logic        ack_prev = 1'b0;
  logic [71:0] last_data = '0;

  // Event counters sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    ack_prev <= ack;
    if (ack !== ack_prev) ack_cnt <= ack_cnt + 1;
    if (frm_err === 1'b1) frm_cnt <= frm_cnt + 1;
    if (par_err === 1'b1) par_cnt <= par_cnt + 1;
    if (pkt_vld === 1'b1 && pkt_rdy === 1'b1) begin
      xfer_cnt  <= xfer_cnt + 1;
      last_data <= pkt_data;
    end
  end

  function automatic logic [6:0] nib_code(input logic [3:0] n);
    case (n)
      4'h0: return 7'h11;  4'h1: return 7'h12;  4'h2: return 7'h14;  4'h3: return 7'h18;
      4'h4: return 7'h21;  4'h5: return 7'h22;  4'h6: return 7'h24;  4'h7: return 7'h28;
      4'h8: return 7'h41;  4'h9: return 7'h42;  4'hA: return 7'h44;  4'hB: return 7'h48;
      4'hC: return 7'h03;  4'hD: return 7'h06;  4'hE: return 7'h0C;  default: return 7'h09;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one symbol transition and let one edge consume it.
  task automatic send(input logic [6:0] code);
    wires   = wires ^ code;
    data_in = wires;
    tick();
  endtask

  task automatic send_pkt(input logic [71:0] d, input bit lng, input int first);
    int len;
    len = lng ? 18 : 10;
    for (int n = first; n < len; n++) send(nib_code(d[4*n +: 4]));
    send(7'h60);
  endtask

  localparam logic [71:0] PKT_S1 = 72'h00_0000_0081_2345_6700;
  localparam logic [71:0] PKT_L1 = 72'h12_3456_789A_BCDE_F002;
  localparam logic [71:0] PKT_S3 = 72'h00_0000_0000_0000_0001;
  localparam logic [71:0] PKT_S4 = 72'h00_0000_0000_0000_0F01;
  localparam logic [71:0] PKT_EV = 72'h00_0000_0000_0000_0011;

  initial begin
    int a0, f0, p0, x0;
    rst_n   = 1'b0;
    data_in = 7'h00;
    pkt_rdy = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_ack",  ack,      0);
    chk("rst_vld",  pkt_vld,  0);
    chk("rst_data", pkt_data, 0);
    chk("rst_long", pkt_long, 0);
    chk("rst_frm",  frm_err,  0);
    chk("rst_par",  par_err,  0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Short packet, one-cycle valid, 11 acks
    a0 = ack_cnt;
    send_pkt(PKT_S1, 1'b0, 0);
    chk("s1_vld",  pkt_vld,  1);
    chk("s1_data", pkt_data, PKT_S1);
    chk("s1_long", pkt_long, 0);
    tick();
    chk("s1_vld_drop", pkt_vld, 0);
    chk("s1_acks", ack_cnt - a0, 11);

    // Long packet
    send_pkt(PKT_L1, 1'b1, 0);
    chk("l1_vld",  pkt_vld,  1);
    chk("l1_data", pkt_data, PKT_L1);
    chk("l1_long", pkt_long, 1);
    tick();

    // Half-symbol held, then completed
    a0 = ack_cnt;
    wires = wires ^ 7'h02; data_in = wires;
    repeat (5) tick();
    chk("half_hold_acks", ack_cnt - a0, 0);
    wires = wires ^ 7'h10; data_in = wires;
    tick(); tick();
    chk("half_done_acks", ack_cnt - a0, 1);
    send_pkt(PKT_S3, 1'b0, 1);
    chk("half_vld",  pkt_vld,  1);
    chk("half_data", pkt_data, PKT_S3);
    tick();

    // Invalid transition mid-packet, discard, then a good packet
    f0 = frm_cnt; x0 = xfer_cnt;
    send(nib_code(4'h1)); send(nib_code(4'h2)); send(nib_code(4'h3));
    send(7'h07);
    send(nib_code(4'h4)); send(nib_code(4'h5)); send(nib_code(4'h6));
    send(7'h60);
    send_pkt(PKT_S4, 1'b0, 0);
    chk("inv_vld",  pkt_vld,  1);
    chk("inv_data", pkt_data, PKT_S4);
    tick();
    chk("inv_frm",  frm_cnt - f0, 1);
    chk("inv_xfer", xfer_cnt - x0, 1);

    // Even parity frame is dropped
    p0 = par_cnt; x0 = xfer_cnt;
    send_pkt(PKT_EV, 1'b0, 0);
    chk("par_vld",   pkt_vld, 0);
    chk("par_pulse", par_err, 1);
    tick();
    chk("par_pulse_end", par_err, 0);
    chk("par_cnt",  par_cnt - p0, 1);
    chk("par_xfer", xfer_cnt - x0, 0);

    // EOP with no nibbles
    f0 = frm_cnt;
    send(7'h60);
    tick();
    chk("eop0_frm", frm_cnt - f0, 1);

    // 19th nibble overflows, following EOP is silent
    f0 = frm_cnt; x0 = xfer_cnt;
    for (int n = 0; n < 19; n++) send(nib_code((n == 0) ? 4'h2 : 4'h0));
    send(7'h60);
    tick();
    chk("ovf_frm",  frm_cnt - f0, 1);
    chk("ovf_xfer", xfer_cnt - x0, 0);

    // Backpressure: second EOP stalls until the first packet is taken
    pkt_rdy = 1'b0;
    send_pkt(PKT_L1, 1'b1, 0);
    chk("bp_first_vld", pkt_vld, 1);
    tick();
    a0 = ack_cnt;
    send_pkt(PKT_S1, 1'b0, 0);
    repeat (3) tick();
    chk("bp_stall_acks", ack_cnt - a0, 10);
    chk("bp_hold_vld",   pkt_vld,  1);
    chk("bp_hold_data",  pkt_data, PKT_L1);
    chk("bp_hold_long",  pkt_long, 1);
    pkt_rdy = 1'b1;
    tick();
    chk("bp_second_vld",  pkt_vld,   1);
    chk("bp_second_data", pkt_data,  PKT_S1);
    chk("bp_second_long", pkt_long,  0);
    chk("bp_first_taken", last_data, PKT_L1);
    tick();
    chk("bp_drained_vld", pkt_vld,   0);
    chk("bp_second_taken", last_data, PKT_S1);
    chk("bp_total_acks", ack_cnt - a0, 11);

    // Asynchronous reset mid-frame with a packet pending
    pkt_rdy = 1'b0;
    send_pkt(PKT_S4, 1'b0, 0);
    chk("pre_rst_vld", pkt_vld, 1);
    send(nib_code(4'h7)); send(nib_code(4'h8)); send(nib_code(4'h9)); send(nib_code(4'hA));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack",  ack,      0);
    chk("mid_rst_vld",  pkt_vld,  0);
    chk("mid_rst_data", pkt_data, 0);
    chk("mid_rst_long", pkt_long, 0);
    chk("mid_rst_frm",  frm_err,  0);
    chk("mid_rst_par",  par_err,  0);
    tick();
    rst_n   = 1'b1;
    pkt_rdy = 1'b1;
    repeat (2) tick();
    send_pkt(PKT_L1, 1'b1, 0);
    chk("post_rst_vld",  pkt_vld,  1);
    chk("post_rst_data", pkt_data, PKT_L1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
